// File: rtl/imm_encode_if.sv
// Handshake bundle for the immediate encoder.
// The master drives input words and out_ready; the slave is the encoder itself.
interface imm_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] base;
  logic [31:0] imm;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  err;

  modport master (
    output in_valid, base, imm, sel, out_ready,
    input  in_ready, out_valid, instr, err
  );

  modport slave (
    input  in_valid, base, imm, sel, out_ready,
    output in_ready, out_valid, instr, err
  );
endinterface

// File: rtl/imm_encode.sv
// Packs a 32-bit immediate into the immediate fields of an RV32I instruction word,
// flags range/alignment/selector problems, and counts flagged words on a two-stage pipe.
module imm_encode #(
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  imm_encode_if.slave         bus,
  input  logic                err_clr,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [2:0] SEL_I = 3'd0;
  localparam logic [2:0] SEL_S = 3'd1;
  localparam logic [2:0] SEL_B = 3'd2;
  localparam logic [2:0] SEL_J = 3'd3;
  localparam logic [2:0] SEL_U = 3'd4;

  logic [31:0] pack_instr;
  logic        range_err, align_err, sel_err;
  logic        fits_12, fits_13, fits_21;

  logic                v1_q, v1_d, v2_q, v2_d;
  logic [31:0]         instr1_q, instr1_d, instr2_q, instr2_d;
  logic [2:0]          err1_q, err1_d, err2_q, err2_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic                in_ready, load2, out_fire;

  // An immediate fits N signed bits when all bits above the sign bit match it.
  assign fits_12 = (&bus.imm[31:11]) | (~|bus.imm[31:11]);
  assign fits_13 = (&bus.imm[31:12]) | (~|bus.imm[31:12]);
  assign fits_21 = (&bus.imm[31:20]) | (~|bus.imm[31:20]);

  always_comb begin
    pack_instr = bus.base;
    range_err  = 1'b0;
    align_err  = 1'b0;
    sel_err    = 1'b0;
    case (bus.sel)
      SEL_I: begin
        pack_instr[31:20] = bus.imm[11:0];
        range_err         = !fits_12;
      end
      SEL_S: begin
        pack_instr[31:25] = bus.imm[11:5];
        pack_instr[11:7]  = bus.imm[4:0];
        range_err         = !fits_12;
      end
      SEL_B: begin
        pack_instr[31]    = bus.imm[12];
        pack_instr[7]     = bus.imm[11];
        pack_instr[30:25] = bus.imm[10:5];
        pack_instr[11:8]  = bus.imm[4:1];
        range_err         = !fits_13;
        align_err         = bus.imm[0];
      end
      SEL_J: begin
        pack_instr[31]    = bus.imm[20];
        pack_instr[19:12] = bus.imm[19:12];
        pack_instr[20]    = bus.imm[11];
        pack_instr[30:21] = bus.imm[10:1];
        range_err         = !fits_21;
        align_err         = bus.imm[0];
      end
      SEL_U: begin
        pack_instr[31:12] = bus.imm[31:12];
        align_err         = |bus.imm[11:0];
      end
      default: sel_err = 1'b1;
    endcase
  end

  // Stage 2 drains whenever it is empty or being taken; stage 1 refills behind it.
  assign in_ready = !v1_q || !v2_q || bus.out_ready;
  assign load2    = !v2_q || bus.out_ready;
  assign out_fire = v2_q && bus.out_ready;

  always_comb begin
    v1_d        = v1_q;
    instr1_d    = instr1_q;
    err1_d      = err1_q;
    v2_d        = v2_q;
    instr2_d    = instr2_q;
    err2_d      = err2_q;
    err_count_d = err_count_q;
    if (in_ready) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        instr1_d = pack_instr;
        err1_d   = {sel_err, align_err, range_err};
      end
    end
    if (load2) begin
      v2_d = v1_q;
      if (v1_q) begin
        instr2_d = instr1_q;
        err2_d   = err1_q;
      end
    end
    // A clear in the same cycle as a flagged transfer takes priority.
    if (err_clr) begin
      err_count_d = '0;
    end else if (out_fire && (err2_q != 3'b000) && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      instr1_q    <= '0;
      err1_q      <= '0;
      v2_q        <= 1'b0;
      instr2_q    <= '0;
      err2_q      <= '0;
      err_count_q <= '0;
    end else begin
      v1_q        <= v1_d;
      instr1_q    <= instr1_d;
      err1_q      <= err1_d;
      v2_q        <= v2_d;
      instr2_q    <= instr2_d;
      err2_q      <= err2_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v2_q;
  assign bus.instr     = instr2_q;
  assign bus.err       = err2_q;
  assign err_count     = err_count_q;

endmodule
